// File: rtl/operand_issue_pkg.sv
// Shared definitions for the register-read / issue stage.
//   REG_COUNT, DATA_W, RIP_W : register count, operand width, RIP width
//   reg_idx_t                : 4-bit architectural register index
//   issue_state_t            : issue-stage FSM states
//   reg_onehot()             : one-hot register mask, gated by a valid bit
package operand_issue_pkg;
    localparam int REG_COUNT = 16;
    localparam int DATA_W    = 64;
    localparam int RIP_W     = 32;
    localparam int REG_IDX_W = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HAZARD = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } issue_state_t;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input reg_idx_t idx, input logic en);
        logic [REG_COUNT-1:0] mask;
        if (en) begin
            mask = 16'h0001 << idx;
        end else begin
            mask = 16'h0000;
        end
        return mask;
    endfunction
endpackage

// File: rtl/operand_issue_reg_scoreboard.sv
// Register in-use scoreboard.
//   clk, reset             : clock, async active-high reset
//   wb*                    : writeback retirement, forms the clear mask
//   setEn, setDest*        : registers claimed by the instruction being accepted
//   query*                 : registers of the instruction waiting in decode
//   hazard                 : a queried register is still in use after this cycle's clear
//   inUse                  : current scoreboard
//   allClear               : no register in use
module reg_scoreboard
    import operand_issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wbValid,
    input  reg_idx_t             wbDestReg,
    input  reg_idx_t             wbDestRegSpecial,
    input  logic                 wbDestRegSpecialValid,
    input  reg_idx_t             wbSourceReg1,
    input  logic                 wbSourceReg1Valid,
    input  reg_idx_t             wbSourceReg2,
    input  logic                 wbSourceReg2Valid,
    input  logic                 setEn,
    input  reg_idx_t             setDestReg,
    input  reg_idx_t             setDestRegSpecial,
    input  logic                 setDestRegSpecialValid,
    input  reg_idx_t             querySource1,
    input  logic                 querySource1Valid,
    input  reg_idx_t             querySource2,
    input  logic                 querySource2Valid,
    input  reg_idx_t             queryDest,
    input  reg_idx_t             queryDestSpecial,
    input  logic                 queryDestSpecialValid,
    output logic                 hazard,
    output logic [REG_COUNT-1:0] inUse,
    output logic                 allClear
);
    logic [REG_COUNT-1:0] in_use_r;
    logic [REG_COUNT-1:0] clear_mask_s;
    logic [REG_COUNT-1:0] set_mask_s;
    logic [REG_COUNT-1:0] post_clear_s;
    logic [REG_COUNT-1:0] query_mask_s;

    // Clear/set masks and the hazard check against the post-clear view,
    // so a same-cycle writeback releases a waiting instruction.
    always_comb begin
        clear_mask_s = 16'h0000;
        set_mask_s   = 16'h0000;
        if (wbValid) begin
            clear_mask_s = reg_onehot(wbDestReg, 1'b1)
                         | reg_onehot(wbDestRegSpecial, wbDestRegSpecialValid)
                         | reg_onehot(wbSourceReg1, wbSourceReg1Valid)
                         | reg_onehot(wbSourceReg2, wbSourceReg2Valid);
        end else begin
            clear_mask_s = 16'h0000;
        end
        if (setEn) begin
            set_mask_s = reg_onehot(setDestReg, 1'b1)
                       | reg_onehot(setDestRegSpecial, setDestRegSpecialValid);
        end else begin
            set_mask_s = 16'h0000;
        end
        post_clear_s = in_use_r & ~clear_mask_s;
        query_mask_s = reg_onehot(querySource1, querySource1Valid)
                     | reg_onehot(querySource2, querySource2Valid)
                     | reg_onehot(queryDest, 1'b1)
                     | reg_onehot(queryDestSpecial, queryDestSpecialValid);
    end

    // Scoreboard update; set is applied after clear so it wins on a shared register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_use_r <= 16'h0000;
        end else begin
            in_use_r <= post_clear_s | set_mask_s;
        end
    end

    assign hazard   = |(post_clear_s & query_mask_s);
    assign inUse    = in_use_r;
    assign allClear = (in_use_r == 16'h0000);
endmodule

// File: rtl/operand_issue.sv
// Register-read and issue stage between decode and execute.
//   decode side  : decodeValidIn / issueReadyOut, instruction fields, killIn
//   regFileIn    : architectural register file
//   wb*          : writeback results (bypass) and scoreboard release
//   execute side : execValidOut / execReadyIn, registered payload
//   status       : regInUseBitMapOut, stallCountOut, haltOut
module operand_issue
    import operand_issue_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              decodeValidIn,
    output logic              issueReadyOut,
    input  logic [RIP_W-1:0]  currentRipIn,
    input  reg_idx_t          sourceReg1In,
    input  logic              sourceReg1ValidIn,
    input  reg_idx_t          sourceReg2In,
    input  logic              sourceReg2ValidIn,
    input  reg_idx_t          destRegIn,
    input  reg_idx_t          destRegSpecialIn,
    input  logic              destRegSpecialValidIn,
    input  logic              killIn,
    input  logic [DATA_W-1:0] regFileIn [REG_COUNT],
    input  logic              wbValidIn,
    input  reg_idx_t          wbDestRegIn,
    input  logic [DATA_W-1:0] wbAluResultIn,
    input  reg_idx_t          wbDestRegSpecialIn,
    input  logic              wbDestRegSpecialValidIn,
    input  logic [DATA_W-1:0] wbAluResultSpecialIn,
    input  reg_idx_t          wbSourceReg1In,
    input  reg_idx_t          wbSourceReg2In,
    input  logic              wbSourceReg1ValidIn,
    input  logic              wbSourceReg2ValidIn,
    output logic              execValidOut,
    input  logic              execReadyIn,
    output logic [RIP_W-1:0]  currentRipOut,
    output logic [DATA_W-1:0] operand1Out,
    output logic [DATA_W-1:0] operand2Out,
    output reg_idx_t          destRegOut,
    output reg_idx_t          destRegSpecialOut,
    output logic              destRegSpecialValidOut,
    output reg_idx_t          sourceRegCode1Out,
    output reg_idx_t          sourceRegCode2Out,
    output logic              sourceRegCode1ValidOut,
    output logic              sourceRegCode2ValidOut,
    output logic              regInUseBitMapOut [REG_COUNT],
    output logic [15:0]       stallCountOut,
    output logic              haltOut
);
    issue_state_t         state_r;
    logic                 exec_valid_r;
    logic                 halt_r;
    logic [15:0]          stall_count_r;
    logic                 hazard_s;
    logic                 sb_all_clear_s;
    logic [REG_COUNT-1:0] in_use_s;
    logic                 issue_ready_s;
    logic [DATA_W-1:0]    operand1_s;
    logic [DATA_W-1:0]    operand2_s;

    // Writeback primary result beats special result, which beats the register file.
    function automatic logic [DATA_W-1:0] bypass_operand(
        input logic              srcValid,
        input reg_idx_t          src,
        input logic [DATA_W-1:0] rfValue,
        input logic              wbValid,
        input reg_idx_t          wbDest,
        input logic [DATA_W-1:0] wbResult,
        input logic              wbSpecialValid,
        input reg_idx_t          wbSpecial,
        input logic [DATA_W-1:0] wbSpecialResult
    );
        logic [DATA_W-1:0] value;
        if (!srcValid) begin
            value = 64'h0;
        end else if (wbValid && (wbDest == src)) begin
            value = wbResult;
        end else if (wbValid && wbSpecialValid && (wbSpecial == src)) begin
            value = wbSpecialResult;
        end else begin
            value = rfValue;
        end
        return value;
    endfunction

    reg_scoreboard u_scoreboard (
        .clk                   (clk),
        .reset                 (reset),
        .wbValid               (wbValidIn),
        .wbDestReg             (wbDestRegIn),
        .wbDestRegSpecial      (wbDestRegSpecialIn),
        .wbDestRegSpecialValid (wbDestRegSpecialValidIn),
        .wbSourceReg1          (wbSourceReg1In),
        .wbSourceReg1Valid     (wbSourceReg1ValidIn),
        .wbSourceReg2          (wbSourceReg2In),
        .wbSourceReg2Valid     (wbSourceReg2ValidIn),
        .setEn                 (issue_ready_s),
        .setDestReg            (destRegIn),
        .setDestRegSpecial     (destRegSpecialIn),
        .setDestRegSpecialValid(destRegSpecialValidIn),
        .querySource1          (sourceReg1In),
        .querySource1Valid     (sourceReg1ValidIn),
        .querySource2          (sourceReg2In),
        .querySource2Valid     (sourceReg2ValidIn),
        .queryDest             (destRegIn),
        .queryDestSpecial      (destRegSpecialIn),
        .queryDestSpecialValid (destRegSpecialValidIn),
        .hazard                (hazard_s),
        .inUse                 (in_use_s),
        .allClear              (sb_all_clear_s)
    );

    // Accept decision and bypassed operand read. Reset gates ready so the
    // decode handshake is quiet while reset is held.
    always_comb begin
        issue_ready_s = 1'b0;
        if (!reset && decodeValidIn && ((state_r == RUN) || (state_r == HAZARD))
            && !hazard_s && (!exec_valid_r || execReadyIn)) begin
            issue_ready_s = 1'b1;
        end else begin
            issue_ready_s = 1'b0;
        end
        operand1_s = bypass_operand(sourceReg1ValidIn, sourceReg1In, regFileIn[sourceReg1In],
                                    wbValidIn, wbDestRegIn, wbAluResultIn,
                                    wbDestRegSpecialValidIn, wbDestRegSpecialIn, wbAluResultSpecialIn);
        operand2_s = bypass_operand(sourceReg2ValidIn, sourceReg2In, regFileIn[sourceReg2In],
                                    wbValidIn, wbDestRegIn, wbAluResultIn,
                                    wbDestRegSpecialValidIn, wbDestRegSpecialIn, wbAluResultSpecialIn);
    end

    // Payload register toward execute; holds while execute is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_valid_r           <= 1'b0;
            currentRipOut          <= 32'h0;
            operand1Out            <= 64'h0;
            operand2Out            <= 64'h0;
            destRegOut             <= 4'h0;
            destRegSpecialOut      <= 4'h0;
            destRegSpecialValidOut <= 1'b0;
            sourceRegCode1Out      <= 4'h0;
            sourceRegCode2Out      <= 4'h0;
            sourceRegCode1ValidOut <= 1'b0;
            sourceRegCode2ValidOut <= 1'b0;
        end else if (issue_ready_s) begin
            exec_valid_r           <= 1'b1;
            currentRipOut          <= currentRipIn;
            operand1Out            <= operand1_s;
            operand2Out            <= operand2_s;
            destRegOut             <= destRegIn;
            destRegSpecialOut      <= destRegSpecialIn;
            destRegSpecialValidOut <= destRegSpecialValidIn;
            sourceRegCode1Out      <= sourceReg1In;
            sourceRegCode2Out      <= sourceReg2In;
            sourceRegCode1ValidOut <= sourceReg1ValidIn;
            sourceRegCode2ValidOut <= sourceReg2ValidIn;
        end else if (execReadyIn) begin
            exec_valid_r <= 1'b0;
        end
    end

    // Issue FSM with registered halt flag and saturating hazard-stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= RUN;
            halt_r        <= 1'b0;
            stall_count_r <= 16'h0000;
        end else begin
            if ((state_r == HAZARD) && decodeValidIn && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'd1;
            end
            case (state_r)
                RUN: begin
                    halt_r <= 1'b0;
                    if (issue_ready_s && killIn) begin
                        state_r <= DRAIN;
                    end else if (decodeValidIn && hazard_s) begin
                        state_r <= HAZARD;
                    end else begin
                        state_r <= RUN;
                    end
                end
                HAZARD: begin
                    halt_r <= 1'b0;
                    if (issue_ready_s && killIn) begin
                        state_r <= DRAIN;
                    end else if (issue_ready_s || !decodeValidIn) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= HAZARD;
                    end
                end
                DRAIN: begin
                    if (sb_all_clear_s && !exec_valid_r) begin
                        state_r <= HALTED;
                        halt_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                        halt_r  <= 1'b0;
                    end
                end
                HALTED: begin
                    state_r <= HALTED;
                    halt_r  <= 1'b1;
                end
                default: begin
                    state_r <= RUN;
                    halt_r  <= 1'b0;
                end
            endcase
        end
    end

    // Unpack the scoreboard vector onto the per-register status outputs.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            regInUseBitMapOut[i] = in_use_s[i];
        end
    end

    assign issueReadyOut = issue_ready_s;
    assign execValidOut  = exec_valid_r;
    assign stallCountOut = stall_count_r;
    assign haltOut       = halt_r;
endmodule
